// File: rtl/seg7_scan_ctrl_if.sv
// Display-update handshake between a value producer (master) and seg7_scan_ctrl (slave).
// Nibble i of upd_data is digit i; nibble 0 is the rightmost digit.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic              upd_valid;
    logic [4*NDIG-1:0] upd_data;
    logic              upd_ready;

    modport master (
        output upd_valid,
        output upd_data,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_data,
        output upd_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    seg7_scan_ctrl_if.slave  upd,
    output logic [3:0]       bcd_out,
    output logic [NDIG-1:0]  an_n,
    output logic             frame_tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NDIG);

    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Every slot opens dark unless the blank phase is configured away.
    localparam state_t SLOT_START = (BLANK_CYC > 0) ? BLANK : SHOW;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              frame_end;

    logic [4*NDIG-1:0] disp, disp_nxt;
    logic [4*NDIG-1:0] pend;
    logic              pend_vld, pend_vld_nxt;
    logic              transfer, commit;

    function automatic logic [3:0] digit_code(input logic [4*NDIG-1:0] val,
                                              input logic [IW-1:0]     i);
        logic [3:0] nib;
        nib = val[4*i +: 4];
`ifdef SEG7_LZB_EN
        if (i != '0 && (val >> (4*i)) == '0) begin
            nib = 4'hF;
        end
`endif
        return nib;
    endfunction

    // ---------------------------------------------------------------- scan FSM
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a signal unassigned (no latches).
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        frame_end = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (en) begin
                    state_nxt = SLOT_START;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = SLOT_START;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        // Disable overrides everything, including a frame that is just completing.
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            frame_end = 1'b0;
        end
    end

    // ------------------------------------------------------ update double buffer
    // While scanning, new data only lands at frame end so no frame mixes two values.
    assign transfer     = upd.upd_valid & upd.upd_ready;
    assign commit       = pend_vld & (frame_end | (state == IDLE));
    assign disp_nxt     = commit ? pend : disp;
    assign pend_vld_nxt = transfer | (pend_vld & ~commit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
        end else begin
            disp     <= disp_nxt;
            pend_vld <= pend_vld_nxt;
            if (transfer) begin
                pend <= upd.upd_data;
            end
        end
    end

    // ---------------------------------------------------------- output registers
    // Outputs are computed from next-state values so the pins line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n          <= '1;
            bcd_out       <= 4'hF;
            frame_tick    <= 1'b0;
            upd.upd_ready <= 1'b1;
        end else begin
            an_n          <= '1;
            bcd_out       <= 4'hF;
            frame_tick    <= frame_end;
            upd.upd_ready <= ~pend_vld_nxt;
            if (state_nxt != IDLE) begin
                bcd_out <= digit_code(disp_nxt, idx_nxt);
            end
            if (state_nxt == SHOW) begin
                an_n <= ~(NDIG'(1) << idx_nxt);
            end
        end
    end
endmodule
